// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle between a requester (master) and the memory side (slave).
// Handshake: a request or a write-data beat transfers on a rising edge where valid && ready; the master
// holds the payload stable until then. Responses have no ready: mem_resp_valid is a one-cycle beat pulse.
interface mem_responder_if;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_req_rw;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_responder.sv
// Backing store of 128-bit beats: masked single-beat writes, 4-beat line read bursts after a fixed latency.
// One request in flight at a time; the FSM state is exported on state_o for observation.
module mem_responder #(
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    mem,
  output logic [1:0]        state_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, RWAIT = 2'd2, RBURST = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [1:0]              beat_q, beat_d;
  logic [DEPTH_BITS-3:0]   line_q, line_d;
  logic [DEPTH_BITS-1:0]   waddr_q, waddr_d;
  logic [127:0]            rd_q;
  logic [127:0]            mem_q [DEPTH];

  logic                    req_ready, data_ready, req_fire, data_fire;
  logic                    wr_en, rd_en, resp_valid;
  logic [DEPTH_BITS-1:0]   req_idx, wr_idx, rd_idx;
  logic [1:0]              rd_beat;
  logic                    unused_addr_bits;

  assign req_idx          = mem.mem_req_addr[DEPTH_BITS-1:0];
  assign unused_addr_bits = ^mem.mem_req_addr[27:DEPTH_BITS];
  assign req_fire         = mem.mem_req_valid && req_ready;
  assign data_fire        = mem.mem_req_data_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (!mem.mem_req_rw)              state_d = RWAIT;
          else if (!mem.mem_req_data_valid) state_d = WDATA;
        end
      end
      WDATA:   if (data_fire)       state_d = IDLE;
      // Leaving at count 1 makes the counter read 0 on the first burst cycle, giving LATENCY-1 wait cycles.
      RWAIT:   if (cnt_q == 4'd1)   state_d = RBURST;
      RBURST:  if (beat_q == 2'd3)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    data_ready = ((state_q == IDLE) || (state_q == WDATA)) && !reset;
    resp_valid = (state_q == RBURST);
    wr_en      = 1'b0;
    wr_idx     = waddr_q;
    if ((state_q == IDLE) && req_fire && mem.mem_req_rw && data_fire) begin
      wr_en  = 1'b1;
      wr_idx = req_idx;
    end else if ((state_q == WDATA) && data_fire) begin
      wr_en  = 1'b1;
    end
    // The array read runs one cycle ahead of the beat being presented.
    rd_en   = (state_q == RWAIT) || ((state_q == RBURST) && (beat_q != 2'd3));
    rd_beat = (state_q == RBURST) ? beat_q + 2'd1 : 2'd0;
    rd_idx  = {line_q, rd_beat};
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    line_d  = line_q;
    waddr_d = waddr_q;
    case (state_q)
      IDLE: begin
        if (req_fire && mem.mem_req_rw) waddr_d = req_idx;
        if (req_fire && !mem.mem_req_rw) begin
          line_d = req_idx[DEPTH_BITS-1:2];
          cnt_d  = 4'(LATENCY - 1);
          beat_d = 2'd0;
        end
      end
      RWAIT:   cnt_d  = cnt_q - 4'd1;
      RBURST:  beat_d = beat_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      waddr_q <= '0;
      rd_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      waddr_q <= waddr_d;
      if (rd_en) rd_q <= mem_q[rd_idx];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 16; i++) begin
        if (mem.mem_req_data_mask[i]) mem_q[wr_idx][8*i +: 8] <= mem.mem_req_data_bits[8*i +: 8];
      end
    end
  end

  assign mem.mem_req_ready      = req_ready;
  assign mem.mem_req_data_ready = data_ready;
  assign mem.mem_resp_valid     = resp_valid;
  assign mem.mem_resp_data      = rd_q;
  assign state_o                = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table of writes/line reads plus hand sequences for
// delayed write data, held requests at LATENCY 2, and reset in the middle of a burst.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_WDATA = 2'd1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus2 ();
  logic [1:0] state, state2;

  mem_responder #(.DEPTH_BITS(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem(bus), .state_o(state)
  );

  mem_responder #(.DEPTH_BITS(10), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .mem(bus2), .state_o(state2)
  );

  typedef struct packed {
    logic               rw;
    logic [27:0]        addr;
    logic [127:0]       data;
    logic [15:0]        mask;
    logic [3:0][127:0]  exp;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add_w(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    vec_t v;
    v = '0;
    v.rw = 1'b1; v.addr = a; v.data = d; v.mask = m;
    vecs.push_back(v);
  endfunction

  function automatic void add_r(input logic [27:0] a, input logic [127:0] e0, input logic [127:0] e1,
                                input logic [127:0] e2, input logic [127:0] e3);
    vec_t v;
    v = '0;
    v.addr = a;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    vecs.push_back(v);
  endfunction

  // Tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b1; bus.mem_req_addr = a;
    bus.mem_req_data_valid = 1'b1; bus.mem_req_data_bits = d; bus.mem_req_data_mask = m;
    @(negedge clk);
    check_bit("wr_ready", bus.mem_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0; bus.mem_req_data_valid = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] a, input logic [3:0][127:0] exp);
    for (int b = 0; b < 4; b++) exp_q.push_back(exp[b]);
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_addr = a;
    @(negedge clk);
    check_bit("rd_req_ready", bus.mem_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      check_bit("rd_valid", bus.mem_resp_valid, (k >= LAT) && (k <= LAT + 3));
      check_bit("rd_busy_ready", bus.mem_req_ready, k == LAT + 4);
      if (bus.mem_resp_valid) begin
        if (exp_q.size() == 0) check_bit("rd_extra_beat", 1'b1, 1'b0);
        else check("rd_data", bus.mem_resp_data, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    check("rd_beats_left", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.mem_req_valid = 0; bus.mem_req_rw = 0; bus.mem_req_addr = '0;
    bus.mem_req_data_valid = 0; bus.mem_req_data_bits = '0; bus.mem_req_data_mask = '0;
    bus2.mem_req_valid = 0; bus2.mem_req_rw = 0; bus2.mem_req_addr = '0;
    bus2.mem_req_data_valid = 0; bus2.mem_req_data_bits = '0; bus2.mem_req_data_mask = '0;

    add_w(28'h10, 128'h0, 16'hFFFF);
    add_w(28'h11, {8{16'h1111}}, 16'hFFFF);
    add_w(28'h12, {8{16'h2222}}, 16'hFFFF);
    add_w(28'h13, {8{16'h3333}}, 16'hFFFF);
    add_r(28'h12, 128'h0, {8{16'h1111}}, {8{16'h2222}}, {8{16'h3333}});
    add_w(28'h20, 128'h0, 16'hFFFF);
    add_w(28'h21, {8{16'hA5A5}}, 16'hFFFF);
    add_w(28'h22, 128'h0, 16'hFFFF);
    add_w(28'h23, 128'h0, 16'hFFFF);
    add_w(28'h20, {128{1'b1}}, 16'h0001);
    add_w(28'h21, {128{1'b1}}, 16'h0000);
    add_w(28'h22, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hF00F);
    add_r(28'h23, 128'hFF, {8{16'hA5A5}}, 128'h01234567_00000000_00000000_76543210, 128'h0);
    add_w(28'h000, 128'h0, 16'hFFFF);
    add_w(28'h002, 128'h0, 16'hFFFF);
    add_w(28'h003, 128'h0, 16'hFFFF);
    add_w(28'h401, {4{32'hDEADBEEF}}, 16'hFFFF);
    add_r(28'h001, 128'h0, {4{32'hDEADBEEF}}, 128'h0, 128'h0);
    add_w(28'h30, 128'h0, 16'hFFFF);
    add_w(28'h31, 128'h0, 16'hFFFF);
    add_w(28'h32, 128'h0, 16'hFFFF);
    add_w(28'h33, 128'h0, 16'hFFFF);

    // Asynchronous reset takes effect without a clock edge.
    #1 reset = 1'b1;
    #1;
    check_bit("rst_req_ready", bus.mem_req_ready, 1'b0);
    check_bit("rst_data_ready", bus.mem_req_data_ready, 1'b0);
    check_bit("rst_resp_valid", bus.mem_resp_valid, 1'b0);
    check("rst_resp_data", bus.mem_resp_data, 128'h0);
    check("rst_state", 128'(state), 128'(S_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("post_rst_ready", bus.mem_req_ready, 1'b1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].rw) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else            do_read(vecs[i].addr, vecs[i].exp);
    end

    // Stray write data with no request must be ignored.
    bus.mem_req_addr = 28'h31; bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits = {128{1'b1}}; bus.mem_req_data_mask = 16'hFFFF;
    @(negedge clk);
    check("stray_state", 128'(state), 128'(S_IDLE));
    @(posedge clk); #1;
    bus.mem_req_data_valid = 1'b0;

    // Write request whose data arrives 3 cycles later.
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b1; bus.mem_req_addr = 28'h30;
    @(negedge clk);
    check_bit("wd_req_ready", bus.mem_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr = 28'h32;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wd_wait_state", 128'(state), 128'(S_WDATA));
      check_bit("wd_wait_ready", bus.mem_req_ready, 1'b0);
      check_bit("wd_wait_data_ready", bus.mem_req_data_ready, 1'b1);
      @(posedge clk); #1;
    end
    bus.mem_req_data_valid = 1'b1; bus.mem_req_data_bits = {8{16'hCAFE}}; bus.mem_req_data_mask = 16'hFFFF;
    @(negedge clk);
    check("wd_data_state", 128'(state), 128'(S_WDATA));
    @(posedge clk); #1;
    bus.mem_req_data_valid = 1'b0;
    @(negedge clk);
    check_bit("wd_done_ready", bus.mem_req_ready, 1'b1);
    check("wd_done_state", 128'(state), 128'(S_IDLE));
    @(posedge clk); #1;
    do_read(28'h33, {128'h0, 128'h0, 128'h0, {8{16'hCAFE}}});

    // LATENCY 2: a read held valid throughout is re-accepted only at T+6, first beat at T+8.
    bus2.mem_req_valid = 1'b1; bus2.mem_req_rw = 1'b0; bus2.mem_req_addr = 28'h0;
    @(negedge clk);
    check_bit("l2_first_ready", bus2.mem_req_ready, 1'b1);
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_bit("l2_valid", bus2.mem_resp_valid, ((k >= 2) && (k <= 5)) || (k == 8));
      check_bit("l2_ready", bus2.mem_req_ready, k == 6);
      @(posedge clk); #1;
    end
    bus2.mem_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset during beat 1 of a burst.
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_addr = 28'h12;
    @(negedge clk);
    check_bit("rb_req_ready", bus.mem_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_bit("rb_valid", bus.mem_resp_valid, k >= LAT);
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    check("rb_beat1_data", bus.mem_resp_data, {8{16'h1111}});
    #2 reset = 1'b1;
    #1;
    check_bit("rb_rst_valid", bus.mem_resp_valid, 1'b0);
    check_bit("rb_rst_ready", bus.mem_req_ready, 1'b0);
    check("rb_rst_data", bus.mem_resp_data, 128'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("rb_post_ready", bus.mem_req_ready, 1'b1);
    check("rb_post_state", 128'(state), 128'(S_IDLE));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_bit("rb_no_beat", bus.mem_resp_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
